// File: rtl/l2_mem_port_if.sv
// Bundle between the L2 controller / main_memory and l2_mem_port.
// The slave modport is the port's own view; the master modport is the environment's view.
interface l2_mem_port_if #(
   parameter int N            = 32,
   parameter int WORDSPERLINE = 2
);
   // req and resp use strict valid/ready: a transfer happens on a rising clk edge
   // where valid && ready. Once valid is raised it holds, with its payload stable,
   // until that edge. The source never waits on ready before raising valid.
   logic                            req_valid;
   logic                            req_ready;
   logic [N-1:0]                    req_addr;
   logic                            req_wb;
   logic [N-1:0]                    req_wb_addr;
   logic [WORDSPERLINE-1:0][N-1:0]  req_wb_data;
   logic                            resp_valid;
   logic                            resp_ready;
   logic [WORDSPERLINE-1:0][N-1:0]  resp_data;
   logic [N-1:0]                    mem_addr;
   logic [WORDSPERLINE-1:0][N-1:0]  mem_data_in;
   logic                            mem_re;
   logic                            mem_we;
   logic [WORDSPERLINE-1:0][N-1:0]  mem_data_out;

   modport slave (
      input  req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready, mem_data_out,
      output req_ready, resp_valid, resp_data, mem_addr, mem_data_in, mem_re, mem_we
   );

   modport master (
      output req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready, mem_data_out,
      input  req_ready, resp_valid, resp_data, mem_addr, mem_data_in, mem_re, mem_we
   );
endinterface

// File: rtl/l2_mem_port.sv
// L2 line-refill initiator: optional victim writeback, then a read of main memory.
// Define L2_MEM_PORT_WB_FWD_EN to answer from the victim data when victim and fill line match.
module l2_mem_port #(
   parameter int N         = 32,
   parameter int ADDRWIDTH = 10,
   parameter int BLOCKSIZE = 8,
   parameter int WORDSIZE  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   l2_mem_port_if.slave       bus,
   output logic [2:0]         dbg_state
);
   localparam int WORDSPERLINE = BLOCKSIZE / WORDSIZE;
   localparam int OFFW         = $clog2(BLOCKSIZE);

   typedef logic [WORDSPERLINE-1:0][N-1:0] line_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WB     = 3'd1,
      RD_REQ = 3'd2,
      RD_CAP = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t        state;
   logic [N-1:0]  fill_idx;
   logic          req_ready_q;
   logic          resp_valid_q;
   line_t         resp_data_q;
   logic [N-1:0]  mem_addr_q;
   line_t         mem_data_in_q;
   logic          mem_re_q;
   logic          mem_we_q;
`ifdef L2_MEM_PORT_WB_FWD_EN
   logic          fwd_hit;
`endif

   // Byte address to line index; offset bits dropped, bits above ADDRWIDTH zeroed.
   function automatic logic [N-1:0] line_index(input logic [N-1:0] a);
      logic [N-1:0] r;
      r                  = '0;
      r[ADDRWIDTH-1:0]   = a[OFFW +: ADDRWIDTH];
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         fill_idx      <= '0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_data_q   <= '0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
         mem_re_q      <= 1'b0;
         mem_we_q      <= 1'b0;
`ifdef L2_MEM_PORT_WB_FWD_EN
         fwd_hit       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  fill_idx    <= line_index(bus.req_addr);
                  req_ready_q <= 1'b0;
                  if (bus.req_wb) begin
                     // mem_data_in doubles as the latched victim line.
                     state         <= WB;
                     mem_we_q      <= 1'b1;
                     mem_addr_q    <= line_index(bus.req_wb_addr);
                     mem_data_in_q <= bus.req_wb_data;
`ifdef L2_MEM_PORT_WB_FWD_EN
                     fwd_hit       <= (line_index(bus.req_wb_addr) == line_index(bus.req_addr));
`endif
                  end else begin
                     state      <= RD_REQ;
                     mem_re_q   <= 1'b1;
                     mem_addr_q <= line_index(bus.req_addr);
                  end
               end
            end
            WB: begin
               mem_we_q      <= 1'b0;
               mem_data_in_q <= '0;
`ifdef L2_MEM_PORT_WB_FWD_EN
               if (fwd_hit) begin
                  resp_data_q  <= mem_data_in_q;
                  resp_valid_q <= 1'b1;
                  state        <= RESP;
               end else
`endif
               begin
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= fill_idx;
                  state      <= RD_REQ;
               end
            end
            RD_REQ: begin
               // Memory registers the read on this edge; address stays put through RD_CAP.
               mem_re_q <= 1'b0;
               state    <= RD_CAP;
            end
            RD_CAP: begin
               resp_data_q  <= bus.mem_data_out;
               resp_valid_q <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               mem_re_q     <= 1'b0;
               mem_we_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_data_in = mem_data_in_q;
   assign bus.mem_re      = mem_re_q;
   assign bus.mem_we      = mem_we_q;
   assign dbg_state       = state;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.req_addr, bus.req_wb_addr};
endmodule

// File: tb/tb_l2_mem_port.sv
// Directed bench for l2_mem_port with a registered-read main_memory model.
// Build with the same L2_MEM_PORT_WB_FWD_EN setting as the RTL.
module tb_l2_mem_port;
   logic       clk;
   logic       rst_n;
   logic [2:0] dbg_state;

   l2_mem_port_if #(.N(32), .WORDSPERLINE(2)) bus ();

   l2_mem_port dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // main_memory model, plus a preload path used only while the DUT is in reset
   logic [63:0] mem [0:1023];
   logic        pre_we;
   logic [9:0]  pre_idx;
   logic [63:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      else if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_data_in;
      if (bus.mem_re) bus.mem_data_out <= mem[bus.mem_addr[9:0]];
   end

   // scoreboard
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // drivers
   task automatic preload(input logic [9:0] idx, input logic [63:0] data);
      pre_we   = 1'b1;
      pre_idx  = idx;
      pre_data = data;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   // Issue one request from a negedge with the DUT idle, track memory-side activity
   // per cycle (cycle 1 = first cycle after the accept edge), then hold resp_ready low
   // for 'hold' cycles while a competing request is offered, and finally hand shake.
   task automatic run_req(input string tag, input logic [31:0] a, input logic wb,
                          input logic [31:0] wa, input logic [63:0] wd,
                          input int exp_we_cyc, input logic [31:0] exp_we_addr,
                          input int exp_re_cyc, input logic [31:0] exp_re_addr,
                          input int exp_lat, input logic [63:0] exp_data, input int hold);
      int          we_cyc, re_cyc, lat;
      logic [31:0] we_addr, re_addr;
      logic [63:0] we_data, held, exp;
      logic        both_hi, din_leak, rdy_hi;
      we_cyc = 0; re_cyc = 0; lat = 0;
      we_addr = '0; re_addr = '0; we_data = '0;
      both_hi = 1'b0; din_leak = 1'b0; rdy_hi = 1'b0;
      exp_q.push_back(exp_data);
      check({tag, " req_ready_before"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid   = 1'b1;
      bus.req_addr    = a;
      bus.req_wb      = wb;
      bus.req_wb_addr = wa;
      bus.req_wb_data = wd;
      bus.resp_ready  = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid   = 1'b0;
      bus.req_addr    = $urandom;
      bus.req_wb      = 1'($urandom_range(0, 1));
      bus.req_wb_addr = $urandom;
      bus.req_wb_data = {$urandom, $urandom};
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus.mem_we && we_cyc == 0) begin
            we_cyc = c; we_addr = bus.mem_addr; we_data = bus.mem_data_in;
         end
         if (bus.mem_re && re_cyc == 0) begin
            re_cyc = c; re_addr = bus.mem_addr;
         end
         if (bus.mem_we && bus.mem_re) both_hi = 1'b1;
         if (!bus.mem_we && bus.mem_data_in != '0) din_leak = 1'b1;
         if (bus.req_ready) rdy_hi = 1'b1;
         if (bus.resp_valid) begin
            lat = c;
            break;
         end
      end
      exp = exp_q.pop_front();
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " we_cycle"}, 64'(we_cyc), 64'(exp_we_cyc));
      if (exp_we_cyc != 0) begin
         check({tag, " we_addr"}, 64'(we_addr), 64'(exp_we_addr));
         check({tag, " we_data"}, we_data, wd);
      end
      check({tag, " re_cycle"}, 64'(re_cyc), 64'(exp_re_cyc));
      if (exp_re_cyc != 0) check({tag, " re_addr"}, 64'(re_addr), 64'(exp_re_addr));
      check({tag, " we_re_exclusive"}, 64'(both_hi), 64'd0);
      check({tag, " data_in_zero"}, 64'(din_leak), 64'd0);
      check({tag, " req_ready_busy"}, 64'(rdy_hi), 64'd0);
      if (lat == 0) begin
         bus.resp_ready = 1'b1;
         @(negedge clk);
         bus.resp_ready = 1'b0;
         return;
      end
      check({tag, " resp_data"}, bus.resp_data, exp);
      held = bus.resp_data;
      for (int h = 0; h < hold; h++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = 32'h28;
         bus.req_wb    = 1'b0;
         @(negedge clk);
         check({tag, " hold_valid"}, 64'(bus.resp_valid), 64'd1);
         check({tag, " hold_data"}, bus.resp_data, held);
         check({tag, " hold_req_ready"}, 64'(bus.req_ready), 64'd0);
         check({tag, " hold_no_re"}, 64'(bus.mem_re), 64'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      check({tag, " post_req_ready"}, 64'(bus.req_ready), 64'd1);
      check({tag, " post_resp_valid"}, 64'(bus.resp_valid), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
      check({tag, " resp_valid"}, 64'(bus.resp_valid), 64'd0);
      check({tag, " resp_data"}, bus.resp_data, 64'd0);
      check({tag, " mem_addr"}, 64'(bus.mem_addr), 64'd0);
      check({tag, " mem_data_in"}, bus.mem_data_in, 64'd0);
      check({tag, " mem_re"}, 64'(bus.mem_re), 64'd0);
      check({tag, " mem_we"}, 64'(bus.mem_we), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n           = 1'b0;
      pre_we          = 1'b0;
      pre_idx         = '0;
      pre_data        = '0;
      bus.req_valid   = 1'b0;
      bus.req_addr    = '0;
      bus.req_wb      = 1'b0;
      bus.req_wb_addr = '0;
      bus.req_wb_data = '0;
      bus.resp_ready  = 1'b0;
      bus.mem_data_out = '0;
      preload(10'd0,  64'h0000_0BAD_0000_0F00);
      preload(10'd2,  64'h0202_0202_2020_2020);
      preload(10'd3,  64'h0303_0303_3030_3030);
      preload(10'd5,  64'h1111_1111_2222_2222);
      preload(10'd8,  64'h0808_0808_8080_8080);
      preload(10'd9,  64'h0909_0909_9090_9090);
      preload(10'd10, 64'hA0A0_A0A0_0A0A_0A0A);
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("idle");

      // plain fill of line 5
      run_req("rd5", 32'h28, 1'b0, 32'h0, 64'h0, 0, 0, 1, 32'd5, 3,
              64'h1111_1111_2222_2222, 0);
      // writeback line 3 then fill line 2
      run_req("wb3_rd2", 32'h10, 1'b1, 32'h18, 64'hDEAD_BEEF_CAFE_F00D, 1, 32'd3, 2, 32'd2, 4,
              64'h0202_0202_2020_2020, 0);
      // fill the just-written line while stalling the response
      run_req("rd3_hold", 32'h18, 1'b0, 32'h0, 64'h0, 0, 0, 1, 32'd3, 3,
              64'hDEAD_BEEF_CAFE_F00D, 10);
      // victim and fill on the same line
`ifdef L2_MEM_PORT_WB_FWD_EN
      run_req("same_line", 32'h40, 1'b1, 32'h40, 64'h1234_5678_9ABC_DEF0, 1, 32'd8, 0, 0, 2,
              64'h1234_5678_9ABC_DEF0, 0);
`else
      run_req("same_line", 32'h40, 1'b1, 32'h40, 64'h1234_5678_9ABC_DEF0, 1, 32'd8, 2, 32'd8, 4,
              64'h1234_5678_9ABC_DEF0, 0);
`endif
      run_req("rd8_after", 32'h44, 1'b0, 32'h0, 64'h0, 0, 0, 1, 32'd8, 3,
              64'h1234_5678_9ABC_DEF0, 0);

      // reset during the writeback cycle
      bus.req_valid   = 1'b1;
      bus.req_addr    = 32'h48;
      bus.req_wb      = 1'b1;
      bus.req_wb_addr = 32'h50;
      bus.req_wb_data = 64'hFFFF_EEEE_DDDD_CCCC;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("rstwb we_before", 64'(bus.mem_we), 64'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rstwb");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstwb req_ready_after", 64'(bus.req_ready), 64'd1);
      check("rstwb no_resp", 64'(bus.resp_valid), 64'd0);
      run_req("rd10_unchanged", 32'h50, 1'b0, 32'h0, 64'h0, 0, 0, 1, 32'd10, 3,
              64'hA0A0_A0A0_0A0A_0A0A, 0);

      // index beyond ADDRWIDTH wraps to line 0, offset bits ignored
      run_req("trunc", 32'h2007, 1'b0, 32'h0, 64'h0, 0, 0, 1, 32'd0, 3,
              64'h0000_0BAD_0000_0F00, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
